// File: rtl/split_ctrl_pkg.sv
// Shared types and default sizes for the 2-way splitter route controller.
package split_ctrl_pkg;

    // Default packet and destination field widths
    localparam int DEF_DATA_W  = 11;
    localparam int DEF_DEST_W  = 4;
    localparam int DEF_CREDITS = 4;
    localparam int DEF_CNT_W   = 16;

    // Sequencer states: wait for a packet, wait for credit, push token, push packet
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_CRED = 2'd1,
        SEND_CTRL = 2'd2,
        SEND_DATA = 2'd3
    } state_e;

    // Output select: 0 = eject locally, 1 = forward
    typedef logic sel_t;

endpackage

// File: rtl/credit_counter.sv
// Per-output credit counter tracking free slots in one downstream buffer.
// Starts full, drops by one when a packet is committed to this output and
// rises by one on each returned credit. A return that would exceed the
// buffer depth leaves the count alone and raises a sticky error flag.
module credit_counter
    import split_ctrl_pkg::*;
#(
    parameter int CREDITS = DEF_CREDITS,
    parameter int CRED_W  = $clog2(CREDITS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    output logic [CRED_W-1:0] count,
    output logic              zero,
    output logic              overflow_err
);

    localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(CREDITS);

    // Credit count and sticky overflow flag; simultaneous inc and dec cancel out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count        <= CRED_FULL;
            overflow_err <= 1'b0;
        end else if (inc && !dec) begin
            if (count == CRED_FULL) begin
                overflow_err <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end else if (dec && !inc) begin
            if (count != '0) begin
                count <= count - 1'b1;
            end
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/split_2_route_ctrl.sv
// Route sequencer in front of a 2-way packet splitter.
// Takes one packet, decides eject (dest == MY_ADDR) or forward, reserves a
// downstream credit for that output, then hands the splitter the route token
// followed by the packet itself. Delivered packets are counted per output.
module split_2_route_ctrl
    import split_ctrl_pkg::*;
#(
    parameter int                 DATA_W  = DEF_DATA_W,
    parameter int                 DEST_W  = DEF_DEST_W,
    parameter logic [DEST_W-1:0]  MY_ADDR = '0,
    parameter int                 CREDITS = DEF_CREDITS,
    parameter int                 CNT_W   = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ctrl_data,
    output logic              ctrl_valid,
    input  logic              ctrl_ready,
    output logic [DATA_W-1:0] dat_data,
    output logic              dat_valid,
    input  logic              dat_ready,
    input  logic [1:0]        credit_ret,
    output logic [CNT_W-1:0]  pkt_cnt0,
    output logic [CNT_W-1:0]  pkt_cnt1,
    output logic              credit_err,
    output logic              busy
);

    localparam int                CRED_W    = $clog2(CREDITS + 1);
    localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(CREDITS);

    state_e              state;
    state_e              state_next;
    logic [DATA_W-1:0]   pkt_q;
    sel_t                sel_q;
    sel_t                sel_in;
    sel_t                sel_cur;
    logic                enter_ctrl;
    logic [1:0]          cred_dec;
    logic [1:0]          cred_zero;
    logic [1:0]          cred_err;
    logic [CRED_W-1:0]   cred_cnt0;
    logic [CRED_W-1:0]   cred_cnt1;

    assign sel_in = sel_t'(in_data[DATA_W-1 -: DEST_W] != MY_ADDR);

    // A credit is taken from the chosen output only on the step into SEND_CTRL
    assign cred_dec[0] = enter_ctrl && (sel_cur == 1'b0);
    assign cred_dec[1] = enter_ctrl && (sel_cur == 1'b1);

    credit_counter #(
        .CREDITS (CREDITS),
        .CRED_W  (CRED_W)
    ) u_credit0 (
        .clk          (clk),
        .reset        (reset),
        .inc          (credit_ret[0]),
        .dec          (cred_dec[0]),
        .count        (cred_cnt0),
        .zero         (cred_zero[0]),
        .overflow_err (cred_err[0])
    );

    credit_counter #(
        .CREDITS (CREDITS),
        .CRED_W  (CRED_W)
    ) u_credit1 (
        .clk          (clk),
        .reset        (reset),
        .inc          (credit_ret[1]),
        .dec          (cred_dec[1]),
        .count        (cred_cnt1),
        .zero         (cred_zero[1]),
        .overflow_err (cred_err[1])
    );

    assign credit_err = |cred_err;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; also decides which output is being charged a credit
    always_comb begin
        state_next = state;
        enter_ctrl = 1'b0;
        sel_cur    = sel_q;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    sel_cur = sel_in;
                    if (!cred_zero[sel_in]) begin
                        state_next = SEND_CTRL;
                        enter_ctrl = 1'b1;
                    end else begin
                        state_next = WAIT_CRED;
                    end
                end
            end
            WAIT_CRED: begin
                if (!cred_zero[sel_q]) begin
                    state_next = SEND_CTRL;
                    enter_ctrl = 1'b1;
                end
            end
            SEND_CTRL: begin
                if (ctrl_ready) begin
                    state_next = SEND_DATA;
                end
            end
            SEND_DATA: begin
                if (dat_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake outputs driven purely from state so they hold steady until accepted
    always_comb begin
        in_ready   = 1'b0;
        ctrl_valid = 1'b0;
        ctrl_data  = 1'b0;
        dat_valid  = 1'b0;
        dat_data   = '0;
        unique case (state)
            IDLE: begin
                in_ready = !reset;
            end
            SEND_CTRL: begin
                ctrl_valid = 1'b1;
                ctrl_data  = sel_q;
            end
            SEND_DATA: begin
                dat_valid = 1'b1;
                dat_data  = pkt_q;
            end
            default: begin
            end
        endcase
    end

    assign busy = (state != IDLE);

    // Capture the packet and its route when it is accepted in IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_q <= '0;
            sel_q <= 1'b0;
        end else if ((state == IDLE) && in_valid) begin
            pkt_q <= in_data;
            sel_q <= sel_in;
        end
    end

    // Saturating delivered-packet counters, bumped on the data handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else if ((state == SEND_DATA) && dat_ready) begin
            if (sel_q == 1'b0) begin
                if (pkt_cnt0 != '1) begin
                    pkt_cnt0 <= pkt_cnt0 + 1'b1;
                end
            end else begin
                if (pkt_cnt1 != '1) begin
                    pkt_cnt1 <= pkt_cnt1 + 1'b1;
                end
            end
        end
    end

    // Credit counts can never climb above the downstream buffer depth
    assert property (@(posedge clk) disable iff (reset)
        (cred_cnt0 <= CRED_FULL) && (cred_cnt1 <= CRED_FULL));

endmodule
